// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer: FSM state encoding and default byte width.
package alu_result_serializer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_LSB = 2'd1,
    SEND_MSB = 2'd2
  } ser_state_t;

endpackage

// File: rtl/alu_result_serializer_result_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is the head entry, shown combinationally.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers 2*DATA_WIDTH-bit ALU results and streams them out LSB byte first over valid/ready.
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    TX_READY,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  output logic                    FULL,
  output logic                    BUSY,
  output logic                    OVERRUN
);

  ser_state_t              state, state_nxt;
  logic [2*DATA_WIDTH-1:0] hold;
  logic [2*DATA_WIDTH-1:0] fifo_dout;
  logic                    fifo_full, fifo_empty;
  logic                    pop;

  result_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (OUT_VALID),
    .pop   (pop),
    .din   (ALU_OUT),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pop loads hold at the same edge, so SEND_MSB can chain straight into the next LSB.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SEND_LSB;
        end
      end
      SEND_LSB: begin
        if (TX_READY) state_nxt = SEND_MSB;
      end
      SEND_MSB: begin
        if (TX_READY) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = SEND_LSB;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      hold    <= '0;
      OVERRUN <= 1'b0;
    end else begin
      state   <= state_nxt;
      if (pop) hold <= fifo_dout;
      OVERRUN <= OUT_VALID && fifo_full;
    end
  end

  always_comb begin
    TX_DATA = '0;
    case (state)
      SEND_LSB: TX_DATA = hold[DATA_WIDTH-1:0];
      SEND_MSB: TX_DATA = hold[2*DATA_WIDTH-1:DATA_WIDTH];
      default:  TX_DATA = '0;
    endcase
  end

  assign TX_VALID = (state != IDLE);
  assign FULL     = fifo_full;
  assign BUSY     = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed + scoreboard bench: expected bytes are queued at stimulus time and popped on each TX handshake.
module tb_alu_result_serializer;

  localparam int DW = 8;
  localparam int FD = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic          OUT_VALID = 1'b0;
  logic          TX_READY = 1'b0;
  logic [DW-1:0] TX_DATA;
  logic          TX_VALID, FULL, BUSY, OVERRUN;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  alu_result_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .TX_READY  (TX_READY),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .FULL      (FULL),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_result(input logic [2*DW-1:0] r);
    sb.push_back(r[DW-1:0]);
    sb.push_back(r[2*DW-1:DW]);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    TX_READY = 1'b1;
    while (BUSY && g < 60) begin
      step();
      g++;
    end
    chk({tag, "_timeout"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  // Every accepted byte must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST && TX_VALID && TX_READY) begin
      if (sb.size() == 0) begin
        chk("tx_unexpected_byte", {24'd0, TX_DATA}, 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", {24'd0, TX_DATA}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    int g;
    // Reset state
    step(); step();
    chk("rst_tx_valid", {31'd0, TX_VALID}, 32'd0);
    chk("rst_tx_data",  {24'd0, TX_DATA},  32'd0);
    chk("rst_full",     {31'd0, FULL},     32'd0);
    chk("rst_busy",     {31'd0, BUSY},     32'd0);
    chk("rst_overrun",  {31'd0, OVERRUN},  32'd0);
    RST = 1'b0;
    step();

    // Single result, two-cycle latency
    ALU_OUT = 16'hA55A; OUT_VALID = 1'b1; TX_READY = 1'b1;
    expect_result(16'hA55A);
    step();
    OUT_VALID = 1'b0;
    chk("single_lat1_valid", {31'd0, TX_VALID}, 32'd0);
    chk("single_lat1_busy",  {31'd0, BUSY},     32'd1);
    step();
    chk("single_lsb_valid", {31'd0, TX_VALID}, 32'd1);
    chk("single_lsb_data",  {24'd0, TX_DATA},  32'h5A);
    step();
    chk("single_msb_data",  {24'd0, TX_DATA},  32'hA5);
    step();
    chk("single_idle_valid", {31'd0, TX_VALID}, 32'd0);
    chk("single_idle_busy",  {31'd0, BUSY},     32'd0);

    // Back-pressure in SEND_LSB
    ALU_OUT = 16'hA55A; OUT_VALID = 1'b1; TX_READY = 1'b0;
    expect_result(16'hA55A);
    step();
    OUT_VALID = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {31'd0, TX_VALID}, 32'd1);
      chk("bp_hold_data",  {24'd0, TX_DATA},  32'h5A);
      step();
    end
    TX_READY = 1'b1;
    step();
    chk("bp_msb_data", {24'd0, TX_DATA}, 32'hA5);
    drain("bp");

    // Fill and overrun
    TX_READY = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      ALU_OUT = 16'(i); OUT_VALID = 1'b1;
      if (i <= 5) expect_result(16'(i));
      step();
      if (i == 5) begin
        chk("fill_full",       {31'd0, FULL},    32'd1);
        chk("fill_no_overrun", {31'd0, OVERRUN}, 32'd0);
      end
    end
    OUT_VALID = 1'b0;
    chk("fill_overrun_pulse", {31'd0, OVERRUN}, 32'd1);
    chk("fill_still_full",    {31'd0, FULL},    32'd1);
    step();
    chk("fill_overrun_clear", {31'd0, OVERRUN}, 32'd0);
    drain("fill");

    // Wrap-around with random TX_READY
    for (int n = 0; n < 3*FD; n++) begin
      g = 0;
      while (sb.size() > 6 && g < 100) begin
        TX_READY = 1'($urandom_range(0, 1));
        step();
        g++;
      end
      ALU_OUT = 16'($urandom); OUT_VALID = 1'b1;
      TX_READY = 1'($urandom_range(0, 1));
      expect_result(ALU_OUT);
      step();
      OUT_VALID = 1'b0;
      chk("wrap_no_overrun", {31'd0, OVERRUN}, 32'd0);
    end
    drain("wrap");

    // Push while FULL with a same-edge pop
    TX_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ALU_OUT = 16'h0011 + 16'(i); OUT_VALID = 1'b1;
      expect_result(ALU_OUT);
      step();
    end
    OUT_VALID = 1'b0;
    chk("sp_full", {31'd0, FULL}, 32'd1);
    TX_READY = 1'b1;
    step();
    ALU_OUT = 16'h0016; OUT_VALID = 1'b1;
    step();
    OUT_VALID = 1'b0;
    chk("sp_overrun", {31'd0, OVERRUN}, 32'd1);
    chk("sp_full_dec", {31'd0, FULL},   32'd0);
    drain("sp");

    // Reset during SEND_MSB with two results buffered
    TX_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ALU_OUT = 16'h0021 + 16'(i); OUT_VALID = 1'b1;
      expect_result(ALU_OUT);
      step();
    end
    OUT_VALID = 1'b0;
    TX_READY = 1'b1;
    step();
    TX_READY = 1'b0;
    chk("mr_in_msb", {24'd0, TX_DATA}, 32'h00);
    RST = 1'b1;
    step();
    sb.delete();
    chk("mr_tx_valid", {31'd0, TX_VALID}, 32'd0);
    chk("mr_busy",     {31'd0, BUSY},     32'd0);
    chk("mr_full",     {31'd0, FULL},     32'd0);
    chk("mr_tx_data",  {24'd0, TX_DATA},  32'd0);
    RST = 1'b0;
    ALU_OUT = 16'hBEEF; OUT_VALID = 1'b1; TX_READY = 1'b1;
    expect_result(16'hBEEF);
    step();
    OUT_VALID = 1'b0;
    step();
    chk("mr_after_lsb", {24'd0, TX_DATA}, 32'hEF);
    drain("mr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
